// File: rtl/vpg_seq_pkg.sv
// Shared types and constants for the video pattern generator sequencer.
package vpg_seq_pkg;

  typedef enum logic [2:0] {
    StReq,
    StWaitUnlock,
    StWaitLock,
    StSettle,
    StRun
  } seq_state_e;

  localparam logic [2:0] WORD_BLANK = 3'd0;
  localparam logic [2:0] WORD_HELLO = 3'd1;
  localparam logic [2:0] WORD_DEAF  = 3'd2;
  localparam logic [2:0] WORD_YOU   = 3'd3;
  localparam logic [2:0] WORD_ME    = 3'd4;
  localparam logic [2:0] WORD_SIGN  = 3'd5;

  localparam int unsigned NUM_WORDS = 5;

  // Entry 0 is the word shown first after entering auto mode.
  localparam logic [NUM_WORDS-1:0][2:0] PLAYLIST =
      {WORD_SIGN, WORD_ME, WORD_YOU, WORD_DEAF, WORD_HELLO};

  localparam int unsigned LOCK_TIMEOUT = 5000000;
  localparam int unsigned MAX_RETRY    = 3;

  // Playlist index step with wrap back to entry 0.
  function automatic logic [2:0] next_idx(input logic [2:0] idx);
    return (idx == 3'(NUM_WORDS - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/vpg_seq_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each debounced rising edge.
module vpg_seq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic             btn_meta;
  logic             btn_sync;
  logic             level_q;
  logic [CntW-1:0]  cnt_q;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk) begin
    btn_meta <= btn_i;
    btn_sync <= btn_meta;
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      if (btn_sync == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= btn_sync;
        cnt_q   <= '0;
        rise_o  <= btn_sync;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/vpg_sequencer.sv
// Video pattern generator control: mode handshake with the PLL controller and
// frame-aligned word scheduling. Define VPG_SEQ_WATCHDOG_EN to add the
// lock-timeout retry logic and the sticky lock_err flag.
module vpg_sequencer
  import vpg_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FRAMES_PER_WORD = 120,
  parameter int unsigned SETTLE_FRAMES   = 2,
  parameter int unsigned UNLOCK_WAIT     = 1024,
  parameter bit          VS_ACTIVE_LOW   = 1'b1
`ifdef VPG_SEQ_WATCHDOG_EN
  , parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] mode_req,
  input  logic [2:0] sw,
  input  logic       auto_en,
  input  logic       next_btn,
  input  logic       vpg_vs,
  input  logic       pll_locked,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic [2:0] word_sel,
  output logic       blank,
  output logic       busy,
  output logic       lock_err
);

  localparam int unsigned WaitW   = $clog2(UNLOCK_WAIT + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_FRAMES + 1);
  localparam int unsigned FrameW  = $clog2(FRAMES_PER_WORD + 1);

  seq_state_e        state;
  logic [WaitW-1:0]  wait_cnt;
  logic [SettleW-1:0] settle_cnt;
  logic [FrameW-1:0] frame_cnt;
  logic [2:0]        play_idx;
  logic              auto_run;
  logic              pending;

  logic vs_meta, vs_sync, vs_prev;
  logic lock_meta, locked_s;
  logic frame_tick;
  logic btn_rise;

  logic              mode_diff;
  logic [FrameW-1:0] frame_inc;
  logic              expire;
  logic [2:0]        idx_adv;

  // Synchronisers; vs is normalised so 1 means sync asserted.
  always_ff @(posedge clk) begin
    vs_meta   <= vpg_vs ^ VS_ACTIVE_LOW;
    vs_sync   <= vs_meta;
    vs_prev   <= vs_sync;
    lock_meta <= pll_locked;
    locked_s  <= lock_meta;
  end

  assign frame_tick = vs_sync & ~vs_prev;

  vpg_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_i (next_btn),
    .rise_o(btn_rise)
  );

  assign mode_diff = (mode_req != mode);
  assign frame_inc = frame_cnt + FrameW'(1);
  assign expire    = (frame_inc == FrameW'(FRAMES_PER_WORD));
  assign idx_adv   = next_idx(play_idx);

`ifdef VPG_SEQ_WATCHDOG_EN
  localparam int unsigned LockW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  logic [LockW-1:0] lock_cnt;
  logic [1:0]       retry_cnt;
  logic             lock_err_q;

  assign lock_err = lock_err_q;
`else
  assign lock_err = 1'b0;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StReq;
      mode        <= '0;
      mode_change <= 1'b0;
      word_sel    <= WORD_BLANK;
      blank       <= 1'b1;
      busy        <= 1'b1;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      frame_cnt   <= '0;
      play_idx    <= '0;
      auto_run    <= 1'b0;
      pending     <= 1'b0;
`ifdef VPG_SEQ_WATCHDOG_EN
      lock_cnt    <= '0;
      retry_cnt   <= '0;
      lock_err_q  <= 1'b0;
`endif
    end else begin
      mode_change <= 1'b0;
      // Button presses and auto-mode history are meaningless outside RUN.
      if (state != StRun) begin
        pending  <= 1'b0;
        auto_run <= 1'b0;
      end

      unique case (state)
        StReq: begin
          mode        <= mode_req;
          mode_change <= 1'b1;
          wait_cnt    <= '0;
          state       <= StWaitUnlock;
        end

        // Timeout covers reconfigurations that never drop lock.
        StWaitUnlock: begin
          if (!locked_s || wait_cnt == WaitW'(UNLOCK_WAIT - 1)) begin
            state <= StWaitLock;
`ifdef VPG_SEQ_WATCHDOG_EN
            lock_cnt <= '0;
`endif
          end else begin
            wait_cnt <= wait_cnt + WaitW'(1);
          end
        end

        StWaitLock: begin
`ifdef VPG_SEQ_WATCHDOG_EN
          // Once lock_err is set the FSM parks here until reset.
          if (!lock_err_q) begin
            if (locked_s) begin
              state      <= StSettle;
              settle_cnt <= '0;
              retry_cnt  <= '0;
            end else if (lock_cnt == LockW'(LOCK_TIMEOUT_CYCLES - 1)) begin
              lock_cnt <= '0;
              if (retry_cnt == 2'(MAX_RETRY)) begin
                lock_err_q <= 1'b1;
              end else begin
                retry_cnt <= retry_cnt + 2'd1;
                state     <= StReq;
              end
            end else begin
              lock_cnt <= lock_cnt + LockW'(1);
            end
          end
`else
          if (locked_s) begin
            state      <= StSettle;
            settle_cnt <= '0;
          end
`endif
        end

        // A mode request that arrived while waiting is honoured here.
        StSettle: begin
          if (frame_tick) begin
            if (settle_cnt == SettleW'(SETTLE_FRAMES - 1)) begin
              if (mode_diff) begin
                state <= StReq;
              end else begin
                state <= StRun;
                blank <= 1'b0;
                busy  <= 1'b0;
              end
            end else begin
              settle_cnt <= settle_cnt + SettleW'(1);
            end
          end
        end

        StRun: begin
          if (mode_diff) begin
            state    <= StReq;
            word_sel <= WORD_BLANK;
            blank    <= 1'b1;
            busy     <= 1'b1;
          end else if (!auto_en) begin
            pending  <= 1'b0;
            auto_run <= 1'b0;
            if (frame_tick) word_sel <= sw;
          end else begin
            // A tick consumes any pending press; a press on the tick itself waits.
            if (frame_tick) begin
              pending <= btn_rise;
            end else if (btn_rise) begin
              pending <= 1'b1;
            end
            if (frame_tick) begin
              if (!auto_run) begin
                auto_run  <= 1'b1;
                play_idx  <= '0;
                frame_cnt <= '0;
                word_sel  <= PLAYLIST[0];
              end else if (pending || expire) begin
                // Press and expiry on the same tick still advance only once.
                play_idx  <= idx_adv;
                frame_cnt <= '0;
                word_sel  <= PLAYLIST[idx_adv];
              end else begin
                frame_cnt <= frame_inc;
              end
            end
          end
        end

        default: state <= StReq;
      endcase
    end
  end

endmodule

// File: tb/tb_vpg_sequencer.sv
// Directed bench for vpg_sequencer. Frames are produced on demand by the
// frame() task; vpg_vs is active low and idles high.
module tb_vpg_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] mode_req;
  logic [2:0] sw;
  logic       auto_en;
  logic       next_btn;
  logic       vpg_vs;
  logic       pll_locked;
  logic [3:0] mode;
  logic       mode_change;
  logic [2:0] word_sel;
  logic       blank;
  logic       busy;
  logic       lock_err;

  int vectors     = 0;
  int miscompares = 0;
  int mc_count    = 0;
  int mc_base;

  always #5 clk = ~clk;

  always @(posedge clk) if (mode_change === 1'b1) mc_count <= mc_count + 1;

  vpg_sequencer #(
    .DEBOUNCE_CYCLES(16),
    .FRAMES_PER_WORD(3),
    .SETTLE_FRAMES  (2),
    .UNLOCK_WAIT    (1024),
    .VS_ACTIVE_LOW  (1'b1)
`ifdef VPG_SEQ_WATCHDOG_EN
    , .LOCK_TIMEOUT_CYCLES(200)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_req   (mode_req),
    .sw         (sw),
    .auto_en    (auto_en),
    .next_btn   (next_btn),
    .vpg_vs     (vpg_vs),
    .pll_locked (pll_locked),
    .mode       (mode),
    .mode_change(mode_change),
    .word_sel   (word_sel),
    .blank      (blank),
    .busy       (busy),
    .lock_err   (lock_err)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One vsync pulse: 4 cycles low, then 6 cycles high.
  task automatic frame();
    vpg_vs = 1'b0;
    cyc(4);
    vpg_vs = 1'b1;
    cyc(6);
  endtask

  task automatic test_reset();
    reset = 1'b1; mode_req = 4'd0; sw = 3'd0; auto_en = 1'b0;
    next_btn = 1'b0; vpg_vs = 1'b1; pll_locked = 1'b1;
    cyc(3);
    vectors++; if (mode !== 4'd0) begin miscompares++; $display("FAIL reset_mode: got %0d want 0", mode); end
    vectors++; if (mode_change !== 1'b0) begin miscompares++; $display("FAIL reset_mode_change: got %b want 0", mode_change); end
    vectors++; if (word_sel !== 3'd0) begin miscompares++; $display("FAIL reset_word_sel: got %0d want 0", word_sel); end
    vectors++; if (blank !== 1'b1) begin miscompares++; $display("FAIL reset_blank: got %b want 1", blank); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
    vectors++; if (lock_err !== 1'b0) begin miscompares++; $display("FAIL reset_lock_err: got %b want 0", lock_err); end
  endtask

  task automatic test_bringup();
    mc_base = mc_count;
    reset = 1'b0;
    cyc(3);
    pll_locked = 1'b0;
    cyc(200);
    pll_locked = 1'b1;
    cyc(10);
    vectors++; if (blank !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL bringup_locked_blank: blank=%b busy=%b want 1 1", blank, busy); end
    frame();
    vectors++; if (blank !== 1'b1) begin miscompares++; $display("FAIL bringup_tick1_blank: got %b want 1", blank); end
    frame();
    vectors++; if (blank !== 1'b0) begin miscompares++; $display("FAIL bringup_tick2_blank: got %b want 0", blank); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bringup_tick2_busy: got %b want 0", busy); end
    vectors++; if (mc_count - mc_base !== 1) begin miscompares++; $display("FAIL bringup_pulses: got %0d want 1", mc_count - mc_base); end
    vectors++; if (mode !== 4'd0) begin miscompares++; $display("FAIL bringup_mode: got %0d want 0", mode); end
  endtask

  task automatic test_manual();
    sw = 3'd1;
    frame();
    vectors++; if (word_sel !== 3'd1) begin miscompares++; $display("FAIL manual_sw1: got %0d want 1", word_sel); end
    sw = 3'd4;
    cyc(5);
    vectors++; if (word_sel !== 3'd1) begin miscompares++; $display("FAIL manual_midframe: got %0d want 1", word_sel); end
    frame();
    vectors++; if (word_sel !== 3'd4) begin miscompares++; $display("FAIL manual_sw4: got %0d want 4", word_sel); end
    sw = 3'd7;
    frame();
    vectors++; if (word_sel !== 3'd7) begin miscompares++; $display("FAIL manual_sw7: got %0d want 7", word_sel); end
  endtask

  task automatic test_auto();
    logic [2:0] exp;
    auto_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      frame();
      exp = 3'(((k / 3) % 5) + 1);
      vectors++;
      if (word_sel !== exp) begin
        miscompares++;
        $display("FAIL auto_frame%0d: got %0d want %0d", k, word_sel, exp);
      end
    end
  endtask

  task automatic test_button();
    // Playlist now at word 1 with 0 frames counted; two more bring it to expiry.
    frame();
    frame();
    vectors++; if (word_sel !== 3'd1) begin miscompares++; $display("FAIL button_pre: got %0d want 1", word_sel); end
    for (int b = 0; b < 5; b++) begin
      next_btn = 1'b1; cyc(1);
      next_btn = 1'b0; cyc(1);
    end
    next_btn = 1'b1; cyc(20);
    next_btn = 1'b0; cyc(20);
    frame();
    vectors++; if (word_sel !== 3'd2) begin miscompares++; $display("FAIL button_with_expiry: got %0d want 2", word_sel); end
    frame();
    frame();
    vectors++; if (word_sel !== 3'd2) begin miscompares++; $display("FAIL button_hold_word: got %0d want 2", word_sel); end
    frame();
    vectors++; if (word_sel !== 3'd3) begin miscompares++; $display("FAIL button_next_expiry: got %0d want 3", word_sel); end
    next_btn = 1'b1; cyc(20);
    next_btn = 1'b0; cyc(20);
    frame();
    vectors++; if (word_sel !== 3'd4) begin miscompares++; $display("FAIL button_early_advance: got %0d want 4", word_sel); end
  endtask

  task automatic test_mode_change();
    mc_base = mc_count;
    mode_req = 4'd3;
    cyc(3);
    vectors++; if (mc_count - mc_base !== 1) begin miscompares++; $display("FAIL modechg_pulse: got %0d want 1", mc_count - mc_base); end
    vectors++; if (mode !== 4'd3) begin miscompares++; $display("FAIL modechg_mode: got %0d want 3", mode); end
    vectors++; if (word_sel !== 3'd0) begin miscompares++; $display("FAIL modechg_word_sel: got %0d want 0", word_sel); end
    vectors++; if (busy !== 1'b1 || blank !== 1'b1) begin miscompares++; $display("FAIL modechg_busy: busy=%b blank=%b want 1 1", busy, blank); end
    for (int f = 0; f < 95; f++) frame();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL modechg_unlock_wait: busy=%b want 1", busy); end
    for (int f = 0; f < 20; f++) frame();
    vectors++; if (busy !== 1'b0 || blank !== 1'b0) begin miscompares++; $display("FAIL modechg_rerun: busy=%b blank=%b want 0 0", busy, blank); end
    vectors++; if (mc_count - mc_base !== 1) begin miscompares++; $display("FAIL modechg_single_pulse: got %0d want 1", mc_count - mc_base); end
  endtask

`ifdef VPG_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    reset = 1'b1; pll_locked = 1'b0; auto_en = 1'b0;
    cyc(3);
    mc_base = mc_count;
    reset = 1'b0;
    cyc(1500);
    vectors++; if (mc_count - mc_base !== 4) begin miscompares++; $display("FAIL wd_pulses: got %0d want 4", mc_count - mc_base); end
    vectors++; if (lock_err !== 1'b1) begin miscompares++; $display("FAIL wd_lock_err: got %b want 1", lock_err); end
    cyc(500);
    vectors++; if (mc_count - mc_base !== 4) begin miscompares++; $display("FAIL wd_no_more_pulses: got %0d want 4", mc_count - mc_base); end
    vectors++; if (lock_err !== 1'b1) begin miscompares++; $display("FAIL wd_sticky: got %b want 1", lock_err); end
    reset = 1'b1;
    cyc(2);
    vectors++; if (lock_err !== 1'b0) begin miscompares++; $display("FAIL wd_reset_clear: got %b want 0", lock_err); end
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_bringup();
    test_manual();
    test_auto();
    test_button();
    test_mode_change();
`ifdef VPG_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
